// File: rtl/apb_master_ctrl.sv
// APB3 requester: takes one command at a time, runs IDLE->SETUP->ACCESS on the
// UART/TIMER bus and returns a single response; a watchdog aborts stalled accesses.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  output logic                  PENABLE,
  output logic                  PSEL_UART,
  output logic                  PSEL_TIMER,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic                  pwrite_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic                  penable_q;
  logic                  psel_uart_q;
  logic                  psel_timer_q;
  logic [CW-1:0]         wd_cnt_q;
  logic [CW-1:0]         wd_cnt_d;

  logic accept;
  logic region_uart;
  logic region_timer;
  logic wd_expire;

  assign accept       = cmd_valid && cmd_ready_q;
  assign region_uart  = (cmd_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b00);
  assign region_timer = (cmd_addr[ADDR_WIDTH-1:ADDR_WIDTH-2] == 2'b01);
  assign wd_cnt_d     = wd_cnt_q + 1'b1;

  // The count holds the number of stalled ACCESS cycles already seen, so the
  // current stalled cycle is the last allowed one when it equals TIMEOUT-1.
  if (TIMEOUT_CYCLES == 0) begin : g_no_wd
    assign wd_expire = 1'b0;
  end else begin : g_wd
    assign wd_expire = (wd_cnt_q == CW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q      <= ST_IDLE;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      penable_q    <= 1'b0;
      psel_uart_q  <= 1'b0;
      psel_timer_q <= 1'b0;
      wd_cnt_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (region_uart || region_timer) begin
              state_q      <= ST_SETUP;
              psel_uart_q  <= region_uart;
              psel_timer_q <= region_timer;
              paddr_q      <= cmd_addr;
              pwrite_q     <= cmd_write;
              pwdata_q     <= cmd_wdata;
            end else begin
              // Unmapped: answer straight away without touching the bus.
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          penable_q <= 1'b1;
          wd_cnt_q  <= '0;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            state_q      <= ST_RESP;
            psel_uart_q  <= 1'b0;
            psel_timer_q <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= PSLVERR;
            rsp_rdata_q  <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            wd_cnt_q     <= '0;
          end else if (wd_expire) begin
            state_q      <= ST_RESP;
            psel_uart_q  <= 1'b0;
            psel_timer_q <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_err_q    <= 1'b1;
            rsp_rdata_q  <= '0;
            wd_cnt_q     <= '0;
          end else begin
            wd_cnt_q <= wd_cnt_d;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign PENABLE    = penable_q;
  assign PSEL_UART  = psel_uart_q;
  assign PSEL_TIMER = psel_timer_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl: directed cases plus random commands
// against a transaction-level expectation model and a reactive APB slave.
module tb_apb_master_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic          PENABLE;
  logic          PSEL_UART;
  logic          PSEL_TIMER;
  logic          PREADY = 1'b0;
  logic [DW-1:0] PRDATA = '0;
  logic          PSLVERR = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master_ctrl #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PADDR     (PADDR),
    .PWRITE    (PWRITE),
    .PWDATA    (PWDATA),
    .PENABLE   (PENABLE),
    .PSEL_UART (PSEL_UART),
    .PSEL_TIMER(PSEL_TIMER),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_txn    = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one command, derived from the address map and the
  // number of wait states the slave inserts (cycles counted from the cycle
  // after acceptance, which is 1).
  typedef struct {
    bit          err;
    logic [31:0] rdata;
    int          rsp_cycle;
    int          psel_cycles;
    int          pen_cycles;
    bit          uart;
    bit          timer;
  } exp_t;

  function automatic exp_t model(input bit write, input int addr, input int waits,
                                 input bit slverr, input logic [31:0] prdata);
    exp_t e;
    int   region;
    region  = addr / 256;
    e.uart  = (region == 0);
    e.timer = (region == 1);
    if (region >= 2) begin
      e.err = 1; e.rdata = '0; e.rsp_cycle = 1; e.psel_cycles = 0; e.pen_cycles = 0;
    end else if (TO != 0 && waits >= TO) begin
      e.err = 1; e.rdata = '0; e.rsp_cycle = TO + 2; e.psel_cycles = TO + 1; e.pen_cycles = TO;
    end else begin
      e.err         = slverr;
      e.rdata       = (!write && !slverr) ? prdata : 32'h0;
      e.rsp_cycle   = waits + 3;
      e.psel_cycles = waits + 2;
      e.pen_cycles  = waits + 1;
    end
    return e;
  endfunction

  task automatic run(input bit write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input int waits, input bit slverr, input logic [DW-1:0] prdata,
                     input int rsp_delay, input bit late_pready);
    exp_t e;
    int   c, k, psel_n, pen_n, rsp_at;
    int   bad_excl, bad_bus, bad_sel, bad_pen;
    e = model(write, int'(addr), waits, slverr, prdata);
    @(negedge PCLK);
    check("cmd_ready_idle", 128'(cmd_ready), 128'(1));
    cmd_valid = 1'b1; cmd_write = write; cmd_addr = addr; cmd_wdata = wdata; rsp_ready = 1'b0;
    @(negedge PCLK);
    c = 1; k = 0; psel_n = 0; pen_n = 0; rsp_at = 0;
    bad_excl = 0; bad_bus = 0; bad_sel = 0; bad_pen = 0;
    // Command inputs are scrambled while the block is busy; they must be ignored.
    cmd_valid = 1'($urandom); cmd_write = 1'($urandom); cmd_addr = AW'($urandom); cmd_wdata = $urandom;
    while (rsp_at == 0 && c < 60) begin
      if (PSEL_UART && PSEL_TIMER) bad_excl++;
      if (PSEL_UART || PSEL_TIMER) begin
        psel_n++;
        if (PADDR !== addr || PWRITE !== write || PWDATA !== wdata) bad_bus++;
        if (PSEL_UART !== e.uart || PSEL_TIMER !== e.timer) bad_sel++;
      end else if (PENABLE) begin
        bad_pen++;
      end
      if (PENABLE) pen_n++;
      if (rsp_valid) begin
        rsp_at = c;
      end else begin
        if (PENABLE && (PSEL_UART || PSEL_TIMER)) begin
          k++;
          PREADY = (k > waits);
          PRDATA = (k > waits) ? prdata : $urandom;
          PSLVERR = (k > waits) ? slverr : 1'($urandom);
        end else begin
          PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
        @(negedge PCLK);
        c++;
      end
    end
    check("rsp_latency", 128'(rsp_at), 128'(e.rsp_cycle));
    check("psel_cycles", 128'(psel_n), 128'(e.psel_cycles));
    check("penable_cycles", 128'(pen_n), 128'(e.pen_cycles));
    check("bus_protocol", 128'({bad_excl, bad_bus, bad_sel, bad_pen}), 128'(0));
    check("rsp_err", 128'(rsp_err), 128'(e.err));
    check("rsp_rdata", 128'(rsp_rdata), 128'(e.rdata));
    for (int i = 0; i < rsp_delay; i++) begin
      PREADY = late_pready ? 1'b1 : 1'($urandom);
      PRDATA = $urandom; PSLVERR = 1'($urandom);
      @(negedge PCLK);
      check("rsp_hold", 128'({rsp_valid, rsp_err, rsp_rdata, cmd_ready, PSEL_UART, PSEL_TIMER, PENABLE}),
            128'({1'b1, e.err, e.rdata, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    rsp_ready = 1'b1; cmd_valid = 1'b0; PREADY = 1'b0;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    check("rsp_done", 128'({rsp_valid, cmd_ready}), 128'({1'b0, 1'b1}));
    n_txn++;
    $display("txn %0d: %s addr=%h waits=%0d slverr=%0d -> rsp at %0d err=%0d rdata=%h",
             n_txn, write ? "WR" : "RD", addr, waits, slverr, rsp_at, rsp_err_snapshot(e), e.rdata);
  endtask

  function automatic int rsp_err_snapshot(input exp_t e);
    return int'(e.err);
  endfunction

  initial begin
    // Reset state
    PRESET = 1'b1;
    repeat (3) @(negedge PCLK);
    check("reset_outputs",
          128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL_UART, PSEL_TIMER}),
          128'({1'b1, 80'h0}));
    PRESET = 1'b0;

    // Directed cases
    run(1'b1, 10'h004, 32'hDEADBEEF, 0, 1'b0, 32'h0, 2, 1'b0);
    run(1'b0, 10'h108, 32'h0, 3, 1'b0, 32'h12345678, 0, 1'b0);
    run(1'b0, 10'h200, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1, 1'b0);
    run(1'b0, 10'h000, 32'h0, 40, 1'b0, 32'hA5A5A5A5, 3, 1'b1);
    run(1'b1, 10'h100, 32'h55AA55AA, 0, 1'b1, 32'h0, 4, 1'b0);
    run(1'b0, 10'h0F0, 32'h0, TO - 1, 1'b0, 32'h87654321, 0, 1'b0);
    run(1'b0, 10'h1FC, 32'h0, TO, 1'b0, 32'h87654321, 1, 1'b1);
    run(1'b0, 10'h3FF, 32'h0, 2, 1'b0, 32'h11112222, 0, 1'b0);

    // Random commands
    for (int t = 0; t < 40; t++) begin
      run(1'($urandom), AW'($urandom_range(0, 1023)), $urandom, int'($urandom_range(0, 20)),
          ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 3)), 1'($urandom));
    end

    // Reset in the middle of a read ACCESS
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h004; cmd_wdata = '0; PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("pre_reset_access", 128'({PSEL_UART, PENABLE}), 128'({1'b1, 1'b1}));
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    PREADY = 1'b1; PRDATA = 32'hFFFF0000;
    check("mid_reset_outputs",
          128'({cmd_ready, rsp_valid, rsp_rdata, rsp_err, PADDR, PWRITE, PWDATA, PENABLE, PSEL_UART, PSEL_TIMER}),
          128'({1'b1, 80'h0}));
    repeat (3) @(negedge PCLK);
    check("post_reset_quiet", 128'({rsp_valid, cmd_ready, PSEL_UART, PENABLE}), 128'({1'b0, 1'b1, 1'b0, 1'b0}));
    $display("txn %0d: reset during ACCESS -> response discarded", n_txn + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
